// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and default width for the multiply/divide unit
package mdu_pkg;

    localparam int MDU_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - iterative restoring divider on magnitudes with sign fixup
// quotient/remainder reflect the step being performed this cycle, so they are final during the last step.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              start,
    input  logic              step,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem_q, quo_q, dvsr_q, dvd_q;
    logic              neg_q, neg_r, zero_q;
    logic              dvd_neg, dvsr_neg;
    logic [DATA_W:0]   partial, diff;
    logic              fits;
    logic [DATA_W-1:0] rem_nxt, quo_nxt;

    assign dvd_neg  = is_signed && dividend[DATA_W-1];
    assign dvsr_neg = is_signed && divisor[DATA_W-1];

    // Remainder stays below the divisor, so a borrow out of bit DATA_W means "does not fit".
    assign partial = {rem_q, quo_q[DATA_W-1]};
    assign diff    = partial - {1'b0, dvsr_q};
    assign fits    = !diff[DATA_W];
    assign rem_nxt = fits ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    assign quo_nxt = {quo_q[DATA_W-2:0], fits};

    assign quotient  = zero_q ? '1    : (neg_q ? -quo_nxt : quo_nxt);
    assign remainder = zero_q ? dvd_q : (neg_r ? -rem_nxt : rem_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            dvd_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            zero_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dvd_neg ? -dividend : dividend;
            dvsr_q <= dvsr_neg ? -divisor : divisor;
            dvd_q  <= dividend;
            neg_q  <= dvd_neg ^ dvsr_neg;
            neg_r  <= dvd_neg;
            zero_q <= (divisor == '0);
        end else if (step && !flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - HI/LO multiply/divide unit; define MDU_FAST_MUL_EN for a single-cycle multiplier
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    mdu_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              cur_div;
    logic [DATA_W-1:0] hi, lo;
    logic              accept, is_mul, is_div, last_step;
    logic [DATA_W-1:0] div_q, div_r;
    logic [DATA_W-1:0] commit_hi, commit_lo;

    assign accept    = op_valid && op_ready;
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign last_step = (cnt == CNT_W'(DATA_W - 1));
    assign hi_rdata  = hi;
    assign lo_rdata  = lo;

`ifdef MDU_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_a, fast_b, fast_prod;

    // Sign-extending to full width makes one unsigned multiplier serve both MULT and MULTU.
    assign fast_a    = {{DATA_W{(op == OP_MULT) && src1[DATA_W-1]}}, src1};
    assign fast_b    = {{DATA_W{(op == OP_MULT) && src2[DATA_W-1]}}, src2};
    assign fast_prod = fast_a * fast_b;
`else
    logic [DATA_W-1:0]   mul_hi, mul_lo, mul_cand;
    logic                mul_neg;
    logic                src1_neg, src2_neg;
    logic [DATA_W-1:0]   src1_mag, src2_mag;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_full, mul_prod;

    assign src1_neg = (op == OP_MULT) && src1[DATA_W-1];
    assign src2_neg = (op == OP_MULT) && src2[DATA_W-1];
    assign src1_mag = src1_neg ? -src1 : src1;
    assign src2_mag = src2_neg ? -src2 : src2;
    assign mul_sum  = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_cand} : '0);
    assign mul_full = {mul_sum, mul_lo[DATA_W-1:1]};
    assign mul_prod = mul_neg ? -mul_full : mul_full;
`endif

    always_comb begin
        commit_hi = div_r;
        commit_lo = div_q;
`ifndef MDU_FAST_MUL_EN
        if (!cur_div) begin
            {commit_hi, commit_lo} = mul_prod;
        end
`endif
    end

    mdu_div_core #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (accept && is_div),
        .step      ((state == CALC) && cur_div),
        .is_signed (op == OP_DIV),
        .dividend  (src1),
        .divisor   (src2),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && (is_mul || is_div)) begin
`ifdef MDU_FAST_MUL_EN
                    state_nxt = is_mul ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state == IDLE) && !flush;
        busy     = (state == CALC);
        done     = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            cur_div <= 1'b0;
`ifndef MDU_FAST_MUL_EN
            mul_hi   <= '0;
            mul_lo   <= '0;
            mul_cand <= '0;
            mul_neg  <= 1'b0;
`endif
        end else if (accept) begin
            cnt     <= '0;
            cur_div <= is_div;
            case (op)
                OP_MTHI: hi <= src1;
                OP_MTLO: lo <= src1;
`ifdef MDU_FAST_MUL_EN
                OP_MULT, OP_MULTU: {hi, lo} <= fast_prod;
`else
                OP_MULT, OP_MULTU: begin
                    mul_hi   <= '0;
                    mul_lo   <= src2_mag;
                    mul_cand <= src1_mag;
                    mul_neg  <= src1_neg ^ src2_neg;
                end
`endif
                default: ;
            endcase
        end else if ((state == CALC) && !flush) begin
            cnt <= cnt + 1'b1;
`ifndef MDU_FAST_MUL_EN
            mul_hi <= mul_sum[DATA_W:1];
            mul_lo <= {mul_sum[0], mul_lo[DATA_W-1:1]};
`endif
            if (last_step) begin
                hi <= commit_hi;
                lo <= commit_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - scoreboard bench for mdu_unit (DATA_W=32), honours MDU_FAST_MUL_EN
module tb_mdu_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         op_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic         op_ready, done, busy;
    logic [W-1:0] hi_rdata, lo_rdata;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    mdu_unit #(.DATA_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .done     (done),
        .busy     (busy),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sbv;
        logic [63:0] r, q;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.hi = '0; e.lo = '0; e.lat = MUL_LAT;
        case (o)
            3'd0: begin r = sa * sbv; e.hi = r[63:32]; e.lo = r[31:0]; end
            3'd1: begin r = {32'd0, a} * {32'd0, b}; e.hi = r[63:32]; e.lo = r[31:0]; end
            3'd2: begin
                e.lat = DIV_LAT;
                if (b == '0) begin e.hi = a; e.lo = '1; end
                else begin q = sa / sbv; r = sa % sbv; e.hi = r[31:0]; e.lo = q[31:0]; end
            end
            default: begin
                e.lat = DIV_LAT;
                if (b == '0) begin e.hi = a; e.lo = '1; end
                else begin e.hi = a % b; e.lo = a / b; end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int lat);
        exp_t e, got;
        int   cyc, bound, d0;
        e.hi = eh; e.lo = el; e.lat = lat;
        scb.push_back(e);
        op_valid = 1'b1; op = o; src1 = a; src2 = b;
        bound = 0;
        while (op_ready !== 1'b1 && bound < 100) begin @(posedge clk); #1; bound++; end
        checks++;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL %s accept: op_ready=%b required 1", name, op_ready); end
        d0 = done_cnt;
        @(posedge clk); #1;
        op_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        got = scb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL %s timeout: done=%b required 1", name, done);
        end else begin
            checks++;
            if (cyc != got.lat) begin errors++; $display("FAIL %s latency: got %0d required %0d", name, cyc, got.lat); end
            checks++;
            if (hi_rdata !== got.hi) begin errors++; $display("FAIL %s hi: got %h required %h", name, hi_rdata, got.hi); end
            checks++;
            if (lo_rdata !== got.lo) begin errors++; $display("FAIL %s lo: got %h required %h", name, lo_rdata, got.lo); end
            checks++;
            if (op_ready !== 1'b0) begin errors++; $display("FAIL %s ready_in_done: got %b required 0", name, op_ready); end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || done_cnt != d0 + 1) begin
                errors++; $display("FAIL %s one_pulse: done=%b pulses=%0d required 0/%0d", name, done, done_cnt - d0, 1);
            end
        end
    endtask

    task automatic run_model(input string name, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(o, a, b);
        run_op(name, o, a, b, e.hi, e.lo, e.lat);
    endtask

    task automatic move_to(input logic [2:0] o, input logic [W-1:0] a);
        op_valid = 1'b1; op = o; src1 = a;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hi_rdata !== '0 || lo_rdata !== '0) begin errors++; $display("FAIL reset_hilo: got %h/%h required 0/0", hi_rdata, lo_rdata); end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctl: done=%b busy=%b required 0/0", done, busy); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", op_ready); end
    endtask

    task automatic test_move;
        int d0;
        d0 = done_cnt;
        move_to(3'd4, 32'h1111_0000);
        move_to(3'd5, 32'h0000_2222);
        checks++;
        if (hi_rdata !== 32'h1111_0000 || lo_rdata !== 32'h0000_2222) begin
            errors++; $display("FAIL move_hilo: got %h/%h required 11110000/00002222", hi_rdata, lo_rdata);
        end
        move_to(3'd6, 32'h9999_9999);
        move_to(3'd7, 32'h8888_8888);
        checks++;
        if (hi_rdata !== 32'h1111_0000 || lo_rdata !== 32'h0000_2222 || busy !== 1'b0) begin
            errors++; $display("FAIL illegal_op: got %h/%h busy=%b required 11110000/00002222 busy=0", hi_rdata, lo_rdata, busy);
        end
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL move_done: pulses %0d required 0", done_cnt - d0); end
    endtask

    task automatic test_div;
        run_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("divu_max_16", 3'd3, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, DIV_LAT);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT);
        run_op("div_by_zero", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT);
        run_model("divu_by_zero", 3'd3, 32'hDEAD_BEEF, 32'd0);
        run_model("div_pos_neg", 3'd2, 32'd100, 32'hFFFF_FFF9);
        for (int i = 0; i < 4; i++) begin
            run_model("div_rand", 3'd2 + 3'($urandom_range(0, 1)), $urandom, $urandom_range(1, 40000));
        end
    endtask

    task automatic test_mul;
        run_op("mult_m1_2", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("multu_max_2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
        run_model("mult_min_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            run_model("mul_rand", 3'($urandom_range(0, 1)), $urandom, $urandom);
        end
    endtask

    task automatic test_back_to_back;
        run_model("b2b_first", 3'd1, 32'h0001_0001, 32'h0000_FFFF);
        run_model("b2b_second", 3'd3, 32'h7654_3210, 32'h0000_0123);
        run_model("b2b_third", 3'd0, 32'hFFFF_FF00, 32'h0000_0100);
    endtask

    task automatic test_flush;
        int d0, bound;
        exp_t e;
        move_to(3'd4, 32'h0000_1234);
        move_to(3'd5, 32'h0000_CAFE);
        d0 = done_cnt;
        op_valid = 1'b1; op = 3'd3; src1 = 32'h00FF_0000; src2 = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b required 1", busy); end
        flush = 1'b1;
        #1;
        checks++;
        if (op_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b required 0", op_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: busy=%b ready=%b required 0/1", busy, op_ready); end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || hi_rdata !== 32'h0000_1234 || lo_rdata !== 32'h0000_CAFE) begin
            errors++; $display("FAIL flush_abort: pulses=%0d hi=%h lo=%h required 0/00001234/0000cafe", done_cnt - d0, hi_rdata, lo_rdata);
        end
        flush = 1'b1;
        move_to(3'd4, 32'h0000_DEAD);
        op_valid = 1'b1; op = 3'd2; src1 = 32'd9; src2 = 32'd2;
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        checks++;
        if (hi_rdata !== 32'h0000_1234 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_same_cycle: hi=%h busy=%b required 00001234/0", hi_rdata, busy);
        end
        e = model(3'd3, 32'd100, 32'd7);
        scb.push_back(e);
        d0 = done_cnt;
        op_valid = 1'b1; op = 3'd3; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0;
        bound = 0;
        while (done !== 1'b1 && bound < 100) begin @(posedge clk); #1; bound++; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        e = scb.pop_front();
        checks++;
        if (done_cnt != d0 + 1 || hi_rdata !== e.hi || lo_rdata !== e.lo) begin
            errors++; $display("FAIL flush_in_done: pulses=%0d hi=%h lo=%h required 1/%h/%h", done_cnt - d0, hi_rdata, lo_rdata, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        move_to(3'd4, 32'h0000_AAAA);
        move_to(3'd5, 32'h0000_BBBB);
        d0 = done_cnt;
        op_valid = 1'b1; op = 3'd2; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1; op_valid = 1'b1; op = 3'd4; src1 = 32'h0000_BEEF;
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0;
        checks++;
        if (hi_rdata !== '0 || lo_rdata !== '0) begin errors++; $display("FAIL reset_mid_hilo: got %h/%h required 0/0", hi_rdata, lo_rdata); end
        checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_state: busy=%b ready=%b required 0/1", busy, op_ready); end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || hi_rdata !== '0) begin errors++; $display("FAIL reset_mid_done: pulses=%0d hi=%h required 0/0", done_cnt - d0, hi_rdata); end
    endtask

    initial begin
        test_reset();
        test_move();
        test_div();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width; even, >= 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any in-flight operation (exception from WB).
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  encoding: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6 and 7 ignored (no state change).
REQ-008 SHALL have port src1  input  DATA_W  multiplicand / dividend / MTHI-MTLO data.
REQ-009 SHALL have port src2  input  DATA_W  multiplier / divisor.
REQ-010 SHALL have port done  output  1  one-cycle pulse: MUL/DIV result committed to HI/LO.
REQ-011 SHALL have port busy  output  1  operation in flight (stall request to the pipeline).
REQ-012 SHALL have port hi_rdata  output  DATA_W  current HI register.
REQ-013 SHALL have port lo_rdata  output  DATA_W  current LO register.

Function
REQ-014 SHALL use states IDLE, CALC, DONE; op_ready = (state==IDLE) && !flush; busy = (state==CALC).
REQ-015 SHALL accept a request on the edge where op_valid && op_ready; operands latched at that edge.
REQ-016 SHALL write HI/LO for MTHI/MTLO at the accept edge, remain in IDLE, and assert no done.
REQ-017 SHALL move IDLE->CALC on MUL/DIV accept, run exactly DATA_W iteration cycles, then CALC->DONE, writing HI/LO on the CALC->DONE edge.
REQ-018 SHALL hold done=1 only while in DONE (exactly one cycle); DONE->IDLE unconditionally; hi_rdata/lo_rdata show new values during done.
REQ-019 SHALL give MUL/DIV latency DATA_W+1 cycles from accept edge to done high; back-to-back request is accepted no earlier than the cycle after done.
REQ-020 SHALL produce for MULT/MULTU the 2*DATA_W-bit signed/unsigned product: HI = upper half, LO = lower half.
REQ-021 SHALL produce for DIV/DIVU LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-022 SHALL on divisor zero produce LO = all ones, HI = src1, in normal latency.
REQ-023 SHALL on signed DIV of most-negative by -1 produce LO = most-negative, HI = 0.
REQ-024 SHALL on flush in CALC return to IDLE next edge, leave HI/LO unchanged, assert no done.
REQ-025 SHALL ignore a request presented in the same cycle as flush (not accepted, no HI/LO write).
REQ-026 SHALL not revoke a commit on flush in DONE: HI/LO keep new values, done still pulses.
REQ-027 SHALL hold iteration counter width clog2(DATA_W)+1, no wrap within one operation.

Reset
REQ-028 SHALL on reset force state IDLE, HI=0, LO=0, counter 0, done=0, busy=0; reset overrides flush and op_valid.
REQ-029 SHALL on reset mid-operation discard the operation with no done.

Configuration
REQ-030 SHALL with MDU_FAST_MUL_EN defined compute MULT/MULTU as a single-cycle product: IDLE->DONE directly, done one cycle after accept; DIV unchanged.
REQ-031 SHALL without MDU_FAST_MUL_EN compute MULT/MULTU by iterative shift-add in CALC with REQ-019 latency; no hardware multiplier inferred.

Structure
REQ-032 SHALL place op encodings, state enumeration and default DATA_W in shared package mdu_pkg.
REQ-033 SHALL contain one sub-module mdu_div_core: iterative restoring divider (start, flush, DATA_W-cycle, sign fixup outside or inside, quotient/remainder outputs).

Verification (DATA_W=32)
REQ-034 SHALL cover DIV src1=0xFFFFFFF9 (-7), src2=2 -> done at cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 SHALL cover DIVU 0xFFFFFFFF / 0x10 -> LO=0x0FFFFFFF, HI=0x0000000F; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 SHALL cover MULT 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same -> HI=1, LO=0xFFFFFFFE; done at cycle 1 with MDU_FAST_MUL_EN, 33 without.
REQ-037 SHALL cover DIV 5 / 0 -> LO=0xFFFFFFFF, HI=5.
REQ-038 SHALL cover MTHI 0x1234, then DIVU started and flush at iteration 10 -> no done, HI=0x1234, LO unchanged, op_ready high next cycle.
REQ-039 SHALL cover reset asserted during CALC plus simultaneous op_valid -> IDLE, HI=LO=0, done never pulses, request not accepted.
